// File: rtl/ncc_desc_sender.sv
// ---------------------------------------------------------------------------
// ncc_desc_sender
// Transmit side of the NCC descriptor-load handshake. Reads one 16x16
// descriptor of 8-bit pixels (NUM_WORDS words, 4 pixels per word) from a
// word-addressed buffer. Each word is presented to the NCC loader and held
// until the loader acknowledges it.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   start, base_addr begin a transfer at base_addr (only accepted in IDLE)
//   abort            cancel the transfer in progress
//   mem_rd_en/addr   buffer read strobe/address; data valid one cycle later
//   mem_rd_data      buffer read data
//   desc_data_out    presented word, pixel for column 4g in [31:24]
//   desc_data_ready  desc_data_out valid; held until desc_data_ack
//   desc_data_ack    receiver accepts the word this cycle
//   desc_row/col_grp row and column group of the presented word
//   busy             high in any state other than IDLE
//   done             one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module ncc_desc_sender #(
   parameter int NUM_WORDS = 64,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rd_data,
   output logic [31:0]       desc_data_out,
   output logic              desc_data_ready,
   input  logic              desc_data_ack,
   output logic [3:0]        desc_row,
   output logic [1:0]        desc_col_group,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      WAIT_MEM = 3'd2,
      PRESENT  = 3'd3,
      DONE     = 3'd4
   } state_t;

   localparam logic [5:0] LAST_INDEX = 6'(NUM_WORDS - 1);

   state_t            state;
   state_t            state_next;
   logic [5:0]        index;
   logic [5:0]        index_next;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] base_next;

   // Row/group come straight from the word index register: the group is the
   // low two bits, so it wraps 3->0 before the row advances.
   assign desc_row       = index[5:2];
   assign desc_col_group = index[1:0];

   // Next-state, index and base-address selection.
   always_comb begin
      state_next = state;
      index_next = index;
      base_next  = base;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = FETCH;
               base_next  = base_addr;
               index_next = 6'd0;
            end else begin
               state_next = IDLE;
            end
         end
         FETCH:    state_next = WAIT_MEM;
         WAIT_MEM: state_next = PRESENT;
         PRESENT: begin
            if (desc_data_ack) begin
               if (index == LAST_INDEX) begin
                  state_next = DONE;
               end else begin
                  state_next = FETCH;
                  index_next = index + 6'd1;
               end
            end else begin
               state_next = PRESENT;
            end
         end
         DONE: begin
            state_next = IDLE;
            index_next = 6'd0;
         end
         default: begin
            state_next = IDLE;
            index_next = 6'd0;
         end
      endcase
      // Abort wins over everything, including an ack in PRESENT.
      if (abort && (state != IDLE)) begin
         state_next = IDLE;
         index_next = 6'd0;
      end else begin
         state_next = state_next;
      end
   end

   // State register; outputs are registered from the next state so they
   // line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         index           <= 6'd0;
         base            <= '0;
         mem_rd_en       <= 1'b0;
         mem_addr        <= '0;
         desc_data_out   <= 32'd0;
         desc_data_ready <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         state           <= state_next;
         index           <= index_next;
         base            <= base_next;
         mem_rd_en       <= (state_next == FETCH);
         desc_data_ready <= (state_next == PRESENT);
         busy            <= (state_next != IDLE);
         done            <= (state_next == DONE);
         // Address wraps modulo 2^ADDR_W by truncation.
         if (state_next == FETCH) begin
            mem_addr <= base_next + ADDR_W'(index_next);
         end else begin
            mem_addr <= mem_addr;
         end
         // Read data is only meaningful in WAIT_MEM; ignore it elsewhere.
         if (state == WAIT_MEM) begin
            desc_data_out <= mem_rd_data;
         end else begin
            desc_data_out <= desc_data_out;
         end
      end
   end

endmodule

// File: tb/tb_ncc_desc_sender.sv
// ---------------------------------------------------------------------------
// tb_ncc_desc_sender
// Directed bench for ncc_desc_sender. A buffer model returns {4{k[7:0]}} for
// word k of the current descriptor and random data when not read. Expected
// read addresses and words are queued when a transfer is started and
// popped by a monitor as the DUT issues reads and completes transfers.
// ---------------------------------------------------------------------------
module tb_ncc_desc_sender;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic        abort;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic [31:0] desc_data_out;
   logic        desc_data_ready;
   logic        desc_data_ack;
   logic [3:0]  desc_row;
   logic [1:0]  desc_col_group;
   logic        busy;
   logic        done;

   int vectors     = 0;
   int miscompares = 0;
   int done_count  = 0;

   logic [15:0] cur_base;
   logic [15:0] mem_off;
   logic [31:0] exp_data_q[$];
   logic [5:0]  exp_idx_q[$];
   logic [15:0] exp_addr_q[$];
   logic [31:0] mon_d;
   logic [5:0]  mon_i;

   ncc_desc_sender #(.NUM_WORDS(64), .ADDR_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base_addr      (base_addr),
      .abort          (abort),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_rd_data    (mem_rd_data),
      .desc_data_out  (desc_data_out),
      .desc_data_ready(desc_data_ready),
      .desc_data_ack  (desc_data_ack),
      .desc_row       (desc_row),
      .desc_col_group (desc_col_group),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer model: one-cycle read latency, garbage when not read.
   always @(posedge clk) begin
      mem_off = mem_addr - cur_base;
      mem_rd_data <= mem_rd_en ? {4{mem_off[7:0]}} : $urandom();
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: reads and transfers are checked against the scoreboard.
   always begin
      @(negedge clk);
      #1;
      if (done) done_count++;
      if (mem_rd_en) begin
         check("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
         if (exp_addr_q.size() != 0) check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (desc_data_ready && desc_data_ack && !abort && !rst) begin
         check("xfer_expected", 32'(exp_data_q.size() != 0), 32'd1);
         if (exp_data_q.size() != 0) begin
            mon_d = exp_data_q.pop_front();
            mon_i = exp_idx_q.pop_front();
            check("data", desc_data_out, mon_d);
            check("row", 32'(desc_row), 32'(mon_i[5:2]));
            check("group", 32'(desc_col_group), 32'(mon_i[1:0]));
         end
      end
   end

   task automatic flush();
      exp_data_q.delete();
      exp_idx_q.delete();
      exp_addr_q.delete();
   endtask

   task automatic push_desc(input logic [15:0] b);
      logic [7:0] k8;
      for (int k = 0; k < 64; k++) begin
         k8 = 8'(k);
         exp_data_q.push_back({4{k8}});
         exp_idx_q.push_back(6'(k));
         exp_addr_q.push_back(b + 16'(k));
      end
   endtask

   // Returns at the negedge of cycle T+1, T being the edge that sampled start.
   task automatic do_start(input logic [15:0] b);
      @(negedge clk);
      base_addr = b;
      cur_base  = b;
      start     = 1'b1;
      push_desc(b);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!desc_data_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_seen", 32'(desc_data_ready), 32'd1);
   endtask

   task automatic wait_done(input int c0, output int cyc);
      cyc = c0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   initial begin
      int cyc;
      int dc;
      rst = 1'b1; start = 1'b0; abort = 1'b0; desc_data_ack = 1'b0;
      base_addr = 16'h0000; cur_base = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(desc_data_ready), 32'd0);
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", desc_data_out, 32'd0);
      check("rst_row", 32'(desc_row), 32'd0);

      // T1: ack tied high, latency and done timing.
      desc_data_ack = 1'b1;
      do_start(16'h0100);
      check("t1_rd_en_c1", 32'(mem_rd_en), 32'd1);
      check("t1_busy_c1", 32'(busy), 32'd1);
      check("t1_ready_c1", 32'(desc_data_ready), 32'd0);
      @(negedge clk);
      check("t1_ready_c2", 32'(desc_data_ready), 32'd0);
      @(negedge clk);
      check("t1_ready_c3", 32'(desc_data_ready), 32'd1);
      check("t1_word0", desc_data_out, 32'h0000_0000);
      wait_done(3, cyc);
      check("t1_done_cycle", 32'(cyc), 32'd193);
      @(negedge clk);
      check("t1_done_pulse", 32'(done), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);
      check("t1_done_count", 32'(done_count), 32'd1);
      check("t1_words_left", 32'(exp_data_q.size()), 32'd0);

      // T2: ack raised early (ignored), then held off 5 cycles on word 10.
      desc_data_ack = 1'b0;
      do_start(16'h2000);
      desc_data_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      desc_data_ack = 1'b0;
      for (int w = 0; w < 64; w++) begin
         wait_ready();
         if (w == 10) begin
            for (int d = 0; d < 5; d++) begin
               check("t2_hold_ready", 32'(desc_data_ready), 32'd1);
               check("t2_hold_data", desc_data_out, 32'h0A0A_0A0A);
               check("t2_hold_row", 32'(desc_row), 32'd2);
               check("t2_hold_group", 32'(desc_col_group), 32'd2);
               @(negedge clk);
            end
            check("t2_hold_ready6", 32'(desc_data_ready), 32'd1);
         end
         desc_data_ack = 1'b1;
         @(negedge clk);
         desc_data_ack = 1'b0;
         check("t2_ready_drop", 32'(desc_data_ready), 32'd0);
      end
      check("t2_done", 32'(done), 32'd1);
      @(negedge clk);
      check("t2_done_count", 32'(done_count), 32'd2);
      check("t2_words_left", 32'(exp_data_q.size()), 32'd0);

      // T3: address wrap past 0xFFFF.
      desc_data_ack = 1'b1;
      do_start(16'hFFFE);
      check("t3_addr0", 32'(mem_addr), 32'h0000_FFFE);
      wait_done(1, cyc);
      @(negedge clk);
      check("t3_addr_left", 32'(exp_addr_q.size()), 32'd0);
      check("t3_words_left", 32'(exp_data_q.size()), 32'd0);

      // T4: abort together with ack on word 20, then restart.
      dc = done_count;
      do_start(16'h0200);
      cyc = 0;
      while (!(desc_data_ready && desc_row == 4'd5 && desc_col_group == 2'd0) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("t4_word20_ready", 32'(desc_data_ready), 32'd1);
      check("t4_word20_data", desc_data_out, 32'h1414_1414);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_ready", 32'(desc_data_ready), 32'd0);
      check("t4_rd_en", 32'(mem_rd_en), 32'd0);
      check("t4_words_left", 32'(exp_data_q.size()), 32'd44);
      flush();
      repeat (3) @(negedge clk);
      check("t4_no_done", 32'(done_count), 32'(dc));
      do_start(16'h0300);
      check("t4_restart_addr", 32'(mem_addr), 32'h0000_0300);
      wait_ready();
      check("t4_restart_row", 32'(desc_row), 32'd0);
      check("t4_restart_group", 32'(desc_col_group), 32'd0);
      wait_done(3, cyc);
      @(negedge clk);
      check("t4_done_count", 32'(done_count), 32'(dc + 1));

      // T5: start pulses mid-transfer and in the DONE cycle are ignored.
      dc = done_count;
      do_start(16'h0400);
      repeat (50) @(negedge clk);
      base_addr = 16'h9999;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(52, cyc);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t5_busy_after_done", 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      check("t5_still_idle", 32'(busy), 32'd0);
      check("t5_done_count", 32'(done_count), 32'(dc + 1));
      check("t5_words_left", 32'(exp_data_q.size()), 32'd0);

      // T6: asynchronous reset while a word is presented.
      desc_data_ack = 1'b0;
      do_start(16'h0600);
      wait_ready();
      #2 rst = 1'b1;
      #1;
      check("t6_ready_async", 32'(desc_data_ready), 32'd0);
      check("t6_busy_async", 32'(busy), 32'd0);
      check("t6_rd_en_async", 32'(mem_rd_en), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      flush();
      repeat (5) @(negedge clk);
      check("t6_idle_busy", 32'(busy), 32'd0);
      check("t6_idle_rd_en", 32'(mem_rd_en), 32'd0);
      do_start(16'h0700);
      check("t6_new_addr", 32'(mem_addr), 32'h0000_0700);
      check("t6_new_row", 32'(desc_row), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t6_abort_busy", 32'(busy), 32'd0);
      flush();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
